color_cmd_driver: RTL and testbench



---
 rtl/color_pkg.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/color_cmd_driver.sv | 121 ++++++++++++
 tb/tb_color_cmd_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// Shared types and codes for the Color command/response link.
package color_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic {
        COLOR_BLUE = 1'b0,
        COLOR_RED  = 1'b1
    } color_t;

    localparam logic [CMD_W-1:0] CMD_TOGGLE = 2'h1;
    localparam logic [CMD_W-1:0] CMD_HOLD   = 2'h0;
    localparam logic [CMD_W-1:0] CMD_IDLE   = 2'h3;

    localparam logic [CMD_W-1:0] RSP_RED  = 2'h2;
    localparam logic [CMD_W-1:0] RSP_BLUE = 2'h1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEER = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_t;

    // Response code the FSM reports while sitting in colour c.
    function automatic logic [CMD_W-1:0] rsp_code(input color_t c);
        return (c == COLOR_RED) ? RSP_RED : RSP_BLUE;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/color_cmd_driver.sv
// Initiator for the Color FSM: steers to a target colour, holds, and checks
// each response against a shadow of the FSM state.
module color_cmd_driver
    import color_pkg::*;
#(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_color,
    input  logic [CNT_W-1:0] req_hold,
    output logic [CMD_W-1:0] cmd,
    input  logic [CMD_W-1:0] rsp,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             shadow_color
);

    drv_state_t       state_q,  state_d;
    color_t           shadow_q, shadow_d;
    color_t           target_q, target_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             mismatch_q;

    logic             chk_en;
    logic [CMD_W-1:0] exp_rsp;
    logic             fail;

    // Next-state and command decode; cmd depends on registers only.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        cmd       = CMD_IDLE;
        chk_en    = 1'b0;
        exp_rsp   = RSP_RED;
        req_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    target_d = color_t'(req_color);
                    cnt_d    = req_hold;
                    state_d  = ST_STEER;
                end
            end
            ST_STEER: begin
                if (shadow_q != target_q) begin
                    cmd      = CMD_TOGGLE;
                    shadow_d = (shadow_q == COLOR_RED) ? COLOR_BLUE : COLOR_RED;
                    chk_en   = 1'b1;
                    exp_rsp  = rsp_code(shadow_d);
                end
                // A zero hold count skips the hold phase entirely.
                state_d = (cnt_q == '0) ? ST_DONE : ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    if (shadow_q == COLOR_RED) begin
                        cmd     = CMD_HOLD;
                        chk_en  = 1'b1;
                        exp_rsp = RSP_RED;
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fail = chk_en && (rsp != exp_rsp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shadow_q   <= COLOR_RED;
            target_q   <= COLOR_RED;
            cnt_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            mismatch_q <= fail;
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (fail),
        .clr_i   (1'b0),
        .count_o (err_count)
    );

    assign mismatch     = mismatch_q;
    assign shadow_color = shadow_q;

endmodule

// File: tb/tb_color_cmd_driver.sv
// Directed bench for color_cmd_driver against a behavioural Color FSM with
// response corruption.
module tb_color_cmd_driver;
    import color_pkg::*;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_color;
    logic [CNT_W-1:0] req_hold;
    logic [1:0]       cmd;
    logic [1:0]       rsp;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic             shadow_color;

    logic             bad_rsp;
    logic             fsm_red;

    int n_cmp = 0;
    int n_bad = 0;

    color_cmd_driver #(
        .CNT_W(CNT_W),
        .ERR_W(ERR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_color    (req_color),
        .req_hold     (req_hold),
        .cmd          (cmd),
        .rsp          (rsp),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .err_count    (err_count),
        .shadow_color (shadow_color)
    );

    always #5 clk = ~clk;

    // Behavioural Color FSM (resets to Red) with optional corrupted response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              fsm_red <= 1'b1;
        else if (cmd == 2'h1) fsm_red <= ~fsm_red;
    end

    always_comb begin
        rsp = 2'h0;
        if (bad_rsp)           rsp = 2'h3;
        else if (cmd == 2'h1)  rsp = fsm_red ? 2'h1 : 2'h2;
        else if (cmd == 2'h0)  rsp = fsm_red ? 2'h2 : 2'h0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int pulses;
    int dones;
    bit found;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_color = 1'b0;
        req_hold  = '0;
        bad_rsp   = 1'b0;
        step();
        step();
        chk("rst_cmd",      32'(cmd), 32'h3);
        chk("rst_ready",    32'(req_ready), 32'h1);
        chk("rst_busy",     32'(busy), 32'h0);
        chk("rst_done",     32'(done), 32'h0);
        chk("rst_mismatch", 32'(mismatch), 32'h0);
        chk("rst_err",      32'(err_count), 32'h0);
        chk("rst_shadow",   32'(shadow_color), 32'h1);
        rst = 1'b0;
        step();

        // {Blue, hold 2}: cmd 1,3,3,3 and done in cycle 4
        req_valid = 1'b1; req_color = 1'b0; req_hold = 8'd2;
        step();
        req_valid = 1'b0;
        chk("t1_c1_cmd",   32'(cmd), 32'h1);
        chk("t1_c1_ready", 32'(req_ready), 32'h0);
        chk("t1_c1_busy",  32'(busy), 32'h1);
        step();
        chk("t1_c2_cmd", 32'(cmd), 32'h3);
        step();
        chk("t1_c3_cmd",  32'(cmd), 32'h3);
        chk("t1_c3_done", 32'(done), 32'h0);
        step();
        chk("t1_c4_cmd",  32'(cmd), 32'h3);
        chk("t1_c4_done", 32'(done), 32'h1);
        step();
        chk("t1_c5_done",   32'(done), 32'h0);
        chk("t1_c5_ready",  32'(req_ready), 32'h1);
        chk("t1_err",       32'(err_count), 32'h0);
        chk("t1_shadow",    32'(shadow_color), 32'h0);

        // {Red, hold 0} with {Red, hold 3} queued behind it
        req_valid = 1'b1; req_color = 1'b1; req_hold = 8'd0;
        step();
        chk("t2_c1_cmd", 32'(cmd), 32'h1);
        req_hold = 8'd3;
        step();
        chk("t2_c2_done",  32'(done), 32'h1);
        chk("t2_c2_ready", 32'(req_ready), 32'h0);
        step();
        chk("t2_c3_ready", 32'(req_ready), 32'h1);
        chk("t2_c3_done",  32'(done), 32'h0);
        step();
        req_valid = 1'b0;
        chk("t2_steer_cmd",  32'(cmd), 32'h3);
        chk("t2_steer_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t2_hold%0d_cmd", i), 32'(cmd), 32'h0);
        end
        step();
        chk("t2_done",   32'(done), 32'h1);
        chk("t2_err",    32'(err_count), 32'h0);
        chk("t2_shadow", 32'(shadow_color), 32'h1);
        step();

        // Corrupted response on a TOGGLE
        req_valid = 1'b1; req_color = 1'b0; req_hold = 8'd1;
        step();
        req_valid = 1'b0;
        chk("t3_c1_cmd", 32'(cmd), 32'h1);
        chk("t3_c1_mm",  32'(mismatch), 32'h0);
        bad_rsp = 1'b1;
        step();
        bad_rsp = 1'b0;
        chk("t3_c2_mm",     32'(mismatch), 32'h1);
        chk("t3_c2_err",    32'(err_count), 32'h1);
        chk("t3_c2_shadow", 32'(shadow_color), 32'h0);
        step();
        chk("t3_c3_mm",   32'(mismatch), 32'h0);
        chk("t3_c3_done", 32'(done), 32'h1);
        step();

        // Five failures (toggle + four holds) saturate a 2-bit counter
        req_valid = 1'b1; req_color = 1'b1; req_hold = 8'd4;
        bad_rsp = 1'b1;
        pulses = 0;
        dones  = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            req_valid = 1'b0;
            if (mismatch) pulses++;
            if (done) dones++;
        end
        bad_rsp = 1'b0;
        chk("t4_pulses", 32'(pulses), 32'd5);
        chk("t4_dones",  32'(dones), 32'd1);
        chk("t4_err",    32'(err_count), 32'h3);
        chk("t4_shadow", 32'(shadow_color), 32'h1);

        // Reset in the middle of HOLD
        req_valid = 1'b1; req_color = 1'b0; req_hold = 8'd5;
        step();
        req_valid = 1'b0;
        step();
        chk("t5_hold_busy", 32'(busy), 32'h1);
        chk("t5_hold_cmd",  32'(cmd), 32'h3);
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_cmd",    32'(cmd), 32'h3);
        chk("t5_rst_shadow", 32'(shadow_color), 32'h1);
        chk("t5_rst_err",    32'(err_count), 32'h0);
        chk("t5_rst_done",   32'(done), 32'h0);
        chk("t5_rst_ready",  32'(req_ready), 32'h1);
        step();
        rst = 1'b0;
        step();
        req_valid = 1'b1; req_color = 1'b0; req_hold = 8'd1;
        step();
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (done) found = 1'b1;
        end
        chk("t5_post_done",   32'(found), 32'h1);
        chk("t5_post_err",    32'(err_count), 32'h0);
        chk("t5_post_shadow", 32'(shadow_color), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
